// File: rtl/pcie_phy_pkg.sv
// Shared PHY types for the receive-side ordered-set path.
// Includes training-set qualifier states and field-match mask.
package pcie_phy_pkg;

  typedef logic [7:0] rate_id_t;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       compliance;
    logic       no_scramble;
    logic       loopback;
    logic       disable_link;
    logic       hot_reset;
  } training_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_RUN_TS1,
    ST_RUN_TS2
  } ts_qual_state_e;

  localparam logic [7:0] PAD     = 8'hF7;
  localparam logic [7:0] CNT_MAX = 8'hFF;

  // First member is the MSB, so bit 0 is link.
  typedef struct packed {
    logic training_ctrl;
    logic rate_id;
    logic nfts;
    logic lane;
    logic link;
  } cmp_mask_t;

endpackage

// File: rtl/sat_run_counter.sv
// 8-bit run-length counter that saturates at 255.
// clr forces 0, restart forces 1, inc advances.
module sat_run_counter
  import pcie_phy_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       restart_i,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= 8'd0;
    end else if (restart_i) begin
      r_count <= 8'd1;
    end else if (inc_i && (r_count != CNT_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/ts_sequence_qualifier.sv
// Per-lane consecutive TS1/TS2/IDLE run qualifier for the LTSSM.
// Tracks run length and captured training-set fields.
module ts_sequence_qualifier
  import pcie_phy_pkg::*;
#(
  parameter int unsigned TS1_COUNT  = 8,
  parameter int unsigned TS2_COUNT  = 8,
  parameter int unsigned IDLE_COUNT = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic [4:0] cmp_mask_i,
  input  logic       ts1_valid_i,
  input  logic       ts2_valid_i,
  input  logic       idle_valid_i,
  input  logic       eieos_valid_i,
  input  logic [7:0] link_num_i,
  input  logic [7:0] lane_num_i,
  input  logic [7:0] nfts_i,
  input  logic [7:0] rate_id_i,
  input  logic [7:0] training_ctrl_i,
  output logic       ts1_qual_o,
  output logic       ts2_qual_o,
  output logic       idle_qual_o,
  output logic       eieos_seen_o,
  output logic [7:0] run_count_o,
  output logic [7:0] link_num_o,
  output logic [7:0] lane_num_o,
  output logic [7:0] nfts_o,
  output logic [7:0] rate_id_o,
  output logic [7:0] training_ctrl_o,
  output logic       link_pad_o,
  output logic       lane_pad_o
);

  localparam logic [7:0] TS1_TH  = 8'(TS1_COUNT);
  localparam logic [7:0] TS2_TH  = 8'(TS2_COUNT);
  localparam logic [7:0] IDLE_TH = 8'(IDLE_COUNT);

  ts_qual_state_e r_state;
  ts_qual_state_e w_state_nxt;

  logic [7:0]     r_link;
  logic [7:0]     r_lane;
  logic [7:0]     r_nfts;
  rate_id_t       r_rate;
  training_ctrl_t r_tctl;
  logic           r_eieos;

  cmp_mask_t  w_mask;
  logic       w_accept;
  logic       w_same;
  logic       w_match;
  logic       w_continue;
  logic       w_restart;
  logic       w_any_ts;
  logic [7:0] w_run_count;
  logic [7:0] w_idle_count;

  assign w_mask   = cmp_mask_t'(cmp_mask_i);
  assign w_any_ts = ts1_valid_i | ts2_valid_i;
  // Both TS strobes at once is illegal: leave the run alone.
  assign w_accept = ~clear_i & (ts1_valid_i ^ ts2_valid_i);

  assign w_same =
    ((r_state == ST_RUN_TS1) && ts1_valid_i) ||
    ((r_state == ST_RUN_TS2) && ts2_valid_i);

  assign w_match =
    (!w_mask.link || (link_num_i == r_link)) &&
    (!w_mask.lane || (lane_num_i == r_lane)) &&
    (!w_mask.nfts || (nfts_i == r_nfts)) &&
    (!w_mask.rate_id || (rate_id_i == r_rate)) &&
    (!w_mask.training_ctrl ||
     (training_ctrl_i == r_tctl));

  assign w_continue = w_accept & w_same & w_match;
  assign w_restart  = w_accept & ~w_continue;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      clear_i: w_state_nxt = ST_EMPTY;
      w_restart: begin
        w_state_nxt = ts1_valid_i ? ST_RUN_TS1
                                  : ST_RUN_TS2;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_link <= 8'd0;
      r_lane <= 8'd0;
      r_nfts <= 8'd0;
      r_rate <= '0;
      r_tctl <= '0;
    end else if (w_accept) begin
      r_link <= link_num_i;
      r_lane <= lane_num_i;
      r_nfts <= nfts_i;
      r_rate <= rate_id_i;
      r_tctl <= training_ctrl_t'(training_ctrl_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_eieos <= 1'b0;
    end else if (eieos_valid_i) begin
      r_eieos <= 1'b1;
    end
  end

  sat_run_counter u_ts_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clear_i),
    .restart_i (w_restart),
    .inc_i     (w_continue),
    .count_o   (w_run_count)
  );

  sat_run_counter u_idle_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clear_i | w_any_ts),
    .restart_i (1'b0),
    .inc_i     (idle_valid_i),
    .count_o   (w_idle_count)
  );

  assign ts1_qual_o = (r_state == ST_RUN_TS1) &&
                      (w_run_count >= TS1_TH);
  assign ts2_qual_o = (r_state == ST_RUN_TS2) &&
                      (w_run_count >= TS2_TH);
  assign idle_qual_o = (w_idle_count >= IDLE_TH);

  assign eieos_seen_o    = r_eieos;
  assign run_count_o     = w_run_count;
  assign link_num_o      = r_link;
  assign lane_num_o      = r_lane;
  assign nfts_o          = r_nfts;
  assign rate_id_o       = r_rate;
  assign training_ctrl_o = r_tctl;
  assign link_pad_o      = (r_link == PAD);
  assign lane_pad_o      = (r_lane == PAD);

endmodule
